// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32 core, one instruction in flight.
// Latency: zero-wait R/I/JAL/JALR/LUI/AUIPC 4 cycles, LOAD 5, STORE 4, BRANCH 3; strobes are combinational from state.
// Backpressure: FETCH/MEM stall on imem_ready_i/dmem_ready_i up to MEM_TIMEOUT cycles, then trap. Optional macro: SEQ_PERF_CNT_EN.
module core_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 halt_req_i,
  input  logic [6:0]           opcode_i,
  input  logic                 dec_wen_i,
  input  logic                 dec_mem_wen_i,
  input  logic                 imem_ready_i,
  input  logic                 dmem_ready_i,
  output logic                 imem_req_o,
  output logic                 ir_load_o,
  output logic                 dmem_req_o,
  output logic                 mem_wen_o,
  output logic                 rf_wen_o,
  output logic                 pc_en_o,
  output logic                 retire_o,
  output logic                 trapped_o,
  output logic [1:0]           trap_cause_o,
  output logic [2:0]           state_o,
  output logic [CNT_WIDTH-1:0] cycle_cnt_o,
  output logic [CNT_WIDTH-1:0] instr_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [7:0] TIMEOUT   = 8'(MEM_TIMEOUT);

  state_e     state_q;
  logic [7:0] wait_q;
  logic [1:0] cause_q;

  logic   is_load, is_store, is_branch, is_legal, wait_expired;
  state_e retire_next_d;

  assign is_load      = (opcode_i == OP_LOAD);
  assign is_store     = (opcode_i == OP_STORE);
  assign is_branch    = (opcode_i == OP_BRANCH);
  assign is_legal     = opcode_i inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                         7'b1100011, 7'b1100111, 7'b1101111, 7'b0010111,
                                         7'b0110111};
  // Ready in the same cycle as expiry still counts as success, so expiry is checked after ready.
  assign wait_expired = (wait_q == TIMEOUT);
  // halt_req only matters at an instruction boundary.
  assign retire_next_d = halt_req_i ? S_IDLE : S_FETCH;

  // Sequencer state, memory wait counter and sticky trap cause.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      wait_q  <= 8'd0;
      cause_q <= 2'b00;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i && !halt_req_i) begin
            state_q <= S_FETCH;
            wait_q  <= 8'd0;
          end
        end
        S_FETCH: begin
          if (imem_ready_i) begin
            state_q <= S_DECODE;
          end else if (wait_expired) begin
            state_q <= S_TRAP;
            cause_q <= 2'b10;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        S_DECODE: begin
          if (is_legal) begin
            state_q <= S_EXEC;
          end else begin
            state_q <= S_TRAP;
            cause_q <= 2'b01;
          end
        end
        S_EXEC: begin
          if (is_load || is_store) begin
            state_q <= S_MEM;
            wait_q  <= 8'd0;
          end else if (is_branch) begin
            state_q <= retire_next_d;
            wait_q  <= 8'd0;
          end else begin
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ready_i) begin
            if (is_store) begin
              state_q <= retire_next_d;
              wait_q  <= 8'd0;
            end else begin
              state_q <= S_WB;
            end
          end else if (wait_expired) begin
            state_q <= S_TRAP;
            cause_q <= 2'b11;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        S_WB: begin
          state_q <= retire_next_d;
          wait_q  <= 8'd0;
        end
        S_TRAP: state_q <= S_TRAP;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so they drop as soon as reset clears the state.
  always_comb begin
    imem_req_o = 1'b0;
    ir_load_o  = 1'b0;
    dmem_req_o = 1'b0;
    mem_wen_o  = 1'b0;
    rf_wen_o   = 1'b0;
    pc_en_o    = 1'b0;
    retire_o   = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        imem_req_o = 1'b1;
        ir_load_o  = imem_ready_i;
      end
      S_EXEC: begin
        pc_en_o  = is_branch;
        retire_o = is_branch;
      end
      S_MEM: begin
        dmem_req_o = 1'b1;
        mem_wen_o  = dec_mem_wen_i & is_store;
        pc_en_o    = dmem_ready_i & is_store;
        retire_o   = dmem_ready_i & is_store;
      end
      S_WB: begin
        rf_wen_o = dec_wen_i;
        pc_en_o  = 1'b1;
        retire_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign trapped_o    = (state_q == S_TRAP);
  assign trap_cause_o = cause_q;
  assign state_o      = state_q;

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] cycle_cnt_q, instr_cnt_q;
  logic [CNT_WIDTH-1:0] cycle_cnt_d, instr_cnt_d;

  assign cycle_cnt_d = ((state_q != S_IDLE) && (state_q != S_TRAP)) ? cycle_cnt_q + 1'b1 : cycle_cnt_q;
  assign instr_cnt_d = retire_o ? instr_cnt_q + 1'b1 : instr_cnt_q;

  // Free-running performance counters, wrapping naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cycle_cnt_o = cycle_cnt_q;
  assign instr_cnt_o = instr_cnt_q;
`else
  assign cycle_cnt_o = '0;
  assign instr_cnt_o = '0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: per-instruction expectations from a class-level model,
// monitor pops at every retire or trap entry and compares cycles and strobe counts.
module tb_core_sequencer;
  localparam int TO = 255;
`ifdef SEQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic start_i = 0, halt_req_i = 0, dec_wen_i = 0, dec_mem_wen_i = 0;
  logic imem_ready_i = 0, dmem_ready_i = 0;
  logic [6:0] opcode_i = 7'd0;
  logic imem_req_o, ir_load_o, dmem_req_o, mem_wen_o, rf_wen_o, pc_en_o, retire_o, trapped_o;
  logic [1:0] trap_cause_o;
  logic [2:0] state_o;
  logic [31:0] cycle_cnt_o, instr_cnt_o;

  core_sequencer #(.MEM_TIMEOUT(TO), .CNT_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .halt_req_i(halt_req_i),
    .opcode_i(opcode_i), .dec_wen_i(dec_wen_i), .dec_mem_wen_i(dec_mem_wen_i),
    .imem_ready_i(imem_ready_i), .dmem_ready_i(dmem_ready_i),
    .imem_req_o(imem_req_o), .ir_load_o(ir_load_o), .dmem_req_o(dmem_req_o),
    .mem_wen_o(mem_wen_o), .rf_wen_o(rf_wen_o), .pc_en_o(pc_en_o), .retire_o(retire_o),
    .trapped_o(trapped_o), .trap_cause_o(trap_cause_o), .state_o(state_o),
    .cycle_cnt_o(cycle_cnt_o), .instr_cnt_o(instr_cnt_o));

  always #5 clk_i = ~clk_i;

  typedef struct { logic [6:0] op; bit wen; bit mwen; bit halt; int iwait; int dwait; } instr_t;
  typedef struct { int kind; int cyc; int rf; int mw; int cause; int nxt; } exp_t;

  instr_t prog[$];
  exp_t   expq[$];
  int n_checks = 0, n_fail = 0;
  int exp_retired = 0, exp_cycles = 0;

  localparam logic [6:0] LEGAL [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                      7'b1100011, 7'b1100111, 7'b1101111, 7'b0010111, 7'b0110111};

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: outcome of one instruction from its class and the memory wait counts.
  function automatic exp_t model(input instr_t in);
    exp_t e;
    bit ld, st, br, legal, mem, wb;
    e = '{default: 0};
    ld = (in.op == 7'b0000011);
    st = (in.op == 7'b0100011);
    br = (in.op == 7'b1100011);
    legal = 1'b0;
    foreach (LEGAL[i]) if (LEGAL[i] == in.op) legal = 1'b1;
    mem = ld || st;
    wb  = !st && !br;
    if (in.iwait > TO) begin e.kind = 1; e.cause = 2; end
    else if (!legal) begin e.kind = 1; e.cause = 1; end
    else if (mem && in.dwait > TO) begin e.kind = 1; e.cause = 3; end
    else begin
      e.cyc = (in.iwait + 1) + 1 + 1 + (mem ? in.dwait + 1 : 0) + (wb ? 1 : 0);
      e.rf  = wb ? int'(in.wen) : 0;
      e.mw  = (st && in.mwen) ? in.dwait + 1 : 0;
      e.nxt = in.halt ? 0 : 1;
    end
    return e;
  endfunction

  task automatic add_instr(input logic [6:0] op, input bit wen, input bit mwen, input bit halt,
                           input int iwait, input int dwait);
    instr_t in;
    exp_t e;
    in = '{op: op, wen: wen, mwen: mwen, halt: halt, iwait: iwait, dwait: dwait};
    e = model(in);
    prog.push_back(in);
    expq.push_back(e);
    if (e.kind == 0) begin exp_retired++; exp_cycles += e.cyc; end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    start_i = 0; halt_req_i = 0; imem_ready_i = 0; dmem_ready_i = 0;
    prog.delete(); expq.delete();
    exp_retired = 0; exp_cycles = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  // Drives the queued program; memory ready timing follows each instruction's wait counts.
  task automatic run_program(input int abort_st);
    int st, prev, in_cnt;
    bit started;
    instr_t cur;
    prev = -1; in_cnt = 0; started = 0;
    cur = '{op: 7'd0, wen: 0, mwen: 0, halt: 0, iwait: 0, dwait: 0};
    start_i = 1; halt_req_i = 0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(posedge clk_i); #1;
      st = int'(state_o);
      in_cnt = (st == prev) ? in_cnt + 1 : 0;
      prev = st;
      if (st == abort_st) return;
      if (st == 6) begin start_i = 0; return; end
      if (st == 0) begin
        if (started) begin start_i = 0; return; end
        continue;
      end
      started = 1;
      if (st == 1 && in_cnt == 0) begin
        if (prog.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL prog_underrun: fetch with no instruction queued");
          start_i = 0;
          return;
        end
        cur = prog.pop_front();
        opcode_i = cur.op; dec_wen_i = cur.wen; dec_mem_wen_i = cur.mwen;
      end
      start_i      = 1'($urandom_range(0, 1));
      halt_req_i   = (st == 1 || st == 2) ? 1'($urandom_range(0, 1)) : cur.halt;
      imem_ready_i = (st == 1) ? (in_cnt >= cur.iwait) : 1'($urandom_range(0, 1));
      dmem_ready_i = (st == 4) ? (in_cnt >= cur.dwait) : 1'($urandom_range(0, 1));
    end
    n_checks++; n_fail++;
    $display("FAIL prog_budget: program did not finish, state=%0d", state_o);
  endtask

  // Monitor: accumulate strobes per instruction, compare at retire / trap entry.
  int m_st, m_prev = 0, acc_cyc = 0, acc_rf = 0, acc_mw = 0, acc_pc = 0, pend_val = 0;
  bit stray = 0, pend = 0;
  exp_t m_e;
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      acc_cyc = 0; acc_rf = 0; acc_mw = 0; acc_pc = 0; stray = 0; pend = 0; m_prev = 0;
    end else begin
      m_st = int'(state_o);
      if (pend) begin check("state_after_retire", m_st, pend_val); pend = 0; end
      if (m_st >= 1 && m_st <= 5) acc_cyc++;
      if (rf_wen_o) begin acc_rf++; if (m_st != 5) stray = 1; end
      if (mem_wen_o) begin acc_mw++; if (m_st != 4) stray = 1; end
      if (pc_en_o) acc_pc++;
      if (retire_o || (m_st == 6 && m_prev != 6)) begin
        if (expq.size() == 0) begin
          check("unexpected_event_state", m_st, -1);
        end else begin
          m_e = expq.pop_front();
          check("event_kind", (m_st == 6) ? 1 : 0, m_e.kind);
          if (m_st == 6) begin
            check("trap_cause", int'(trap_cause_o), m_e.cause);
            check("trapped_flag", int'(trapped_o), 1);
            check("trap_strobes", int'({imem_req_o, dmem_req_o, mem_wen_o, rf_wen_o, pc_en_o, retire_o}), 0);
          end else begin
            check("instr_cycles", acc_cyc, m_e.cyc);
            check("rf_wen_count", acc_rf, m_e.rf);
            check("mem_wen_count", acc_mw, m_e.mw);
            check("pc_en_count", acc_pc, 1);
            check("strobe_outside_state", int'(stray), 0);
            pend = 1; pend_val = m_e.nxt;
          end
        end
        acc_cyc = 0; acc_rf = 0; acc_mw = 0; acc_pc = 0; stray = 0;
      end
      m_prev = m_st;
    end
  end

  task automatic check_perf(input string name);
    check({name, "_cycle_cnt"}, int'(cycle_cnt_o), PERF ? exp_cycles : 0);
    check({name, "_instr_cnt"}, int'(instr_cnt_o), PERF ? exp_retired : 0);
  endtask

  initial begin
    int k;
    #1;
    check("reset_state", int'(state_o), 0);
    check("reset_strobes", int'({imem_req_o, ir_load_o, dmem_req_o, mem_wen_o, rf_wen_o, pc_en_o, retire_o}), 0);
    check("reset_trap", int'({trapped_o, trap_cause_o}), 0);
    check("reset_cycle_cnt", int'(cycle_cnt_o), 0);
    check("reset_instr_cnt", int'(instr_cnt_o), 0);
    do_reset();

    // ADDI zero-wait, then halt -> IDLE
    add_instr(7'b0010011, 1, 0, 1, 0, 0);
    run_program(-1);
    check("addi_queue_drained", expq.size(), 0);
    check_perf("addi");

    // halt_req noise mid-instruction; ADD halted at boundary
    do_reset();
    add_instr(7'b0110011, 1, 1, 1, 0, 0);
    run_program(-1);
    check_perf("halt_add");

    // LW with dmem ready delayed 3 cycles, then SW with mem write, BEQ, last halts
    do_reset();
    add_instr(7'b0000011, 1, 1, 0, 0, 3);
    add_instr(7'b0100011, 1, 1, 0, 0, 0);
    add_instr(7'b1100011, 1, 1, 0, 0, 0);
    add_instr(7'b0100011, 0, 1, 0, 2, 4);
    add_instr(7'b0010011, 0, 0, 1, 255, 0);
    run_program(-1);
    check("mix_queue_drained", expq.size(), 0);
    check_perf("mix");

    // illegal opcode traps; start toggling is ignored; reset clears
    do_reset();
    add_instr(7'b1111111, 1, 1, 0, 0, 0);
    run_program(-1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_i); #1 start_i = ~start_i;
      check("trap_sticky_state", int'(state_o), 6);
    end
    do_reset();
    check("trap_cleared_state", int'(state_o), 0);
    check("trap_cleared_cause", int'(trap_cause_o), 0);

    // imem never ready -> cause 10; dmem never ready -> cause 11
    add_instr(7'b0010011, 0, 0, 0, 256, 0);
    run_program(-1);
    do_reset();
    add_instr(7'b0000011, 1, 0, 0, 0, 256);
    run_program(-1);
    do_reset();
    add_instr(7'b0000011, 1, 0, 1, 0, 255);
    run_program(-1);
    check("dmem_edge_drained", expq.size(), 0);

    // reset in WB: strobes drop at once, no retire
    do_reset();
    add_instr(7'b0110011, 1, 0, 0, 1, 0);
    run_program(5);
    check("wb_rf_wen_before_reset", int'(rf_wen_o), 1);
    rst_ni = 1'b0;
    #1;
    check("async_reset_rf_wen", int'(rf_wen_o), 0);
    check("async_reset_retire", int'(retire_o), 0);
    check("async_reset_state", int'(state_o), 0);
    do_reset();

    // random legal program
    for (int i = 0; i < 120; i++) begin
      k = $urandom_range(0, 8);
      add_instr(LEGAL[k], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), (i == 119),
                ($urandom_range(0, 7) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 2),
                ($urandom_range(0, 7) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 2));
    end
    run_program(-1);
    check("random_queue_drained", expq.size(), 0);
    check_perf("random");

    @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
